wb_mem_arbiter: RTL and testbench

//  Two-master Wishbone arbiter sharing the single SPI SRAM controller port (spi_sram).
//  M0 = SERV memory bus, M1 = secondary requester (boot loader / debug DMA).

---
 rtl/wb_mem_arbiter.sv | 85 ++++++++
 tb/tb_wb_mem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin two-master Wishbone arbiter in front of one SRAM slave; optional ARB_TIMEOUT_EN force-terminates stuck grants
module wb_mem_arbiter #(
  parameter int AW          = 14,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst,
  input  logic [AW-1:0]   i_m0_adr,
  input  logic [DW-1:0]   i_m0_dat,
  input  logic [DW/8-1:0] i_m0_sel,
  input  logic            i_m0_we,
  input  logic            i_m0_stb,
  output logic [DW-1:0]   o_m0_rdt,
  output logic            o_m0_ack,
  input  logic [AW-1:0]   i_m1_adr,
  input  logic [DW-1:0]   i_m1_dat,
  input  logic [DW/8-1:0] i_m1_sel,
  input  logic            i_m1_we,
  input  logic            i_m1_stb,
  output logic [DW-1:0]   o_m1_rdt,
  output logic            o_m1_ack,
  output logic [AW-1:0]   o_s_adr,
  output logic [DW-1:0]   o_s_dat,
  output logic [DW/8-1:0] o_s_sel,
  output logic            o_s_we,
  output logic            o_s_cyc,
  input  logic [DW-1:0]   i_s_rdt,
  input  logic            i_s_ack,
  output logic            o_timeout
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nxt;
  logic last, last_nxt;
  logic to_hit;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  logic to_flag;
  assign to_hit = state != IDLE && !i_s_ack && cnt == CW'(TIMEOUT_CYC - 1);
  assign o_timeout = to_flag;
  // Count grant cycles without ack, restarting in IDLE; latch a sticky flag on expiry
  always_ff @(posedge i_wb_clk or posedge i_wb_rst)
    if (i_wb_rst) begin
      cnt     <= '0;
      to_flag <= 1'b0;
    end else begin
      cnt     <= state == IDLE ? '0 : cnt + 1'b1;
      to_flag <= to_flag | to_hit;
    end
`else
  assign to_hit = 1'b0;
  assign o_timeout = 1'b0;
`endif
  assign o_m0_ack = state == GNT0 && (i_s_ack || to_hit);
  assign o_m1_ack = state == GNT1 && (i_s_ack || to_hit);
  assign o_m0_rdt = to_hit ? '1 : i_s_rdt;
  assign o_m1_rdt = to_hit ? '1 : i_s_rdt;
  assign o_s_cyc  = state != IDLE;
  assign o_s_adr  = state == GNT0 ? i_m0_adr : state == GNT1 ? i_m1_adr : '0;
  assign o_s_dat  = state == GNT0 ? i_m0_dat : state == GNT1 ? i_m1_dat : '0;
  assign o_s_sel  = state == GNT0 ? i_m0_sel : state == GNT1 ? i_m1_sel : '0;
  assign o_s_we   = state == GNT0 ? i_m0_we : state == GNT1 && i_m1_we;
  // Grant state and last-served master; last starts at M1 so M0 wins the first tie
  always_ff @(posedge i_wb_clk or posedge i_wb_rst)
    if (i_wb_rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  // Arbitrate in IDLE; leave a grant on ack/timeout (recording the winner) or on abort
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    if (state == IDLE)
      state_nxt = i_m0_stb && (!i_m1_stb || last) ? GNT0 : i_m1_stb ? GNT1 : IDLE;
    else if (o_m0_ack || o_m1_ack) begin
      state_nxt = IDLE;
      last_nxt  = o_m1_ack;
    end else if (state == GNT0 ? !i_m0_stb : !i_m1_stb)
      state_nxt = IDLE;
  end
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: table-driven check of grant order, muxing, ack gating, abort, reset and timeout
module tb_wb_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam logic [13:0] A0 = 14'h0010;
  localparam logic [31:0] D0 = 32'h5A5A5A5A;
  localparam logic [3:0]  L0 = 4'hF;
  localparam logic [13:0] A1 = 14'h0ABC;
  localparam logic [31:0] D1 = 32'hCAFEBABE;
  localparam logic [3:0]  L1 = 4'b0011;
  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_dat, m1_dat, s_dat, m0_rdt, m1_rdt, s_rdt;
  logic [3:0] m0_sel, m1_sel, s_sel;
  logic m0_we, m1_we, m0_stb, m1_stb, m0_ack, m1_ack, s_we, s_cyc, s_ack, timeout;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(16)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we), .i_m0_stb(m0_stb),
    .o_m0_rdt(m0_rdt), .o_m0_ack(m0_ack),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we), .i_m1_stb(m1_stb),
    .o_m1_rdt(m1_rdt), .o_m1_ack(m1_ack),
    .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we), .o_s_cyc(s_cyc),
    .i_s_rdt(s_rdt), .i_s_ack(s_ack), .o_timeout(timeout)
  );
  typedef struct {
    logic s0, s1, ack;
    logic [31:0] rdt;
    logic [1:0] g;
    logic k0, k1;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic s0, input logic s1, input logic ack, input logic [1:0] g, input logic k0, input logic k1);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.ack = ack; v.g = g; v.k0 = k0; v.k1 = k1;
    v.rdt = 32'h12345678 + tbl.size() * 32'h01010101;
    tbl.push_back(v);
  endtask
  initial begin
    rst = 1'b1;
    m0_adr = A0; m0_dat = D0; m0_sel = L0; m0_we = 1'b0; m0_stb = 1'b0;
    m1_adr = A1; m1_dat = D1; m1_sel = L1; m1_we = 1'b1; m1_stb = 1'b0;
    s_rdt = '0; s_ack = 1'b0;
    add(1,0,0,0,0,0); add(1,0,0,1,0,0); add(1,0,1,1,1,0); add(0,0,0,0,0,0);
    add(0,1,0,0,0,0); add(0,1,0,2,0,0); add(0,1,1,2,0,1); add(0,0,0,0,0,0);
    for (int k = 0; k < 8; k++) begin
      add(1,1,1,0,0,0);
      add(1,1,1, k % 2 == 1 ? 2'd2 : 2'd1, k % 2 == 0, k % 2 == 1);
    end
    add(0,0,0,0,0,0);
    add(1,0,0,0,0,0); add(1,0,0,1,0,0); add(0,0,0,1,0,0); add(0,0,0,0,0,0);
    add(0,0,1,0,0,0); add(1,1,0,0,0,0); add(1,1,1,1,1,0); add(0,0,0,0,0,0);
    #12;
    chk("reset cyc", s_cyc, 0); chk("reset adr", s_adr, 0); chk("reset we", s_we, 0);
    chk("reset ack0", m0_ack, 0); chk("reset ack1", m1_ack, 0); chk("reset timeout", timeout, 0);
    @(negedge clk) rst = 1'b0;
    foreach (tbl[i]) begin
      @(posedge clk) #1;
      m0_stb = tbl[i].s0; m1_stb = tbl[i].s1; s_ack = tbl[i].ack; s_rdt = tbl[i].rdt;
      @(negedge clk);
      chk($sformatf("r%0d cyc", i), s_cyc, tbl[i].g != 0);
      chk($sformatf("r%0d adr", i), s_adr, tbl[i].g == 1 ? A0 : tbl[i].g == 2 ? A1 : 14'h0);
      chk($sformatf("r%0d dat", i), s_dat, tbl[i].g == 1 ? D0 : tbl[i].g == 2 ? D1 : 32'h0);
      chk($sformatf("r%0d sel", i), s_sel, tbl[i].g == 1 ? L0 : tbl[i].g == 2 ? L1 : 4'h0);
      chk($sformatf("r%0d we", i), s_we, tbl[i].g == 2);
      chk($sformatf("r%0d ack0", i), m0_ack, tbl[i].k0);
      chk($sformatf("r%0d ack1", i), m1_ack, tbl[i].k1);
      chk($sformatf("r%0d rdt0", i), m0_rdt, tbl[i].rdt);
      chk($sformatf("r%0d rdt1", i), m1_rdt, tbl[i].rdt);
    end
    @(posedge clk) #1 m1_stb = 1'b1;
    @(posedge clk) #1;
    chk("gnt1 before rst cyc", s_cyc, 1);
    chk("gnt1 before rst adr", s_adr, A1);
    s_ack = 1'b1; rst = 1'b1;
    #1;
    chk("async rst cyc", s_cyc, 0);
    chk("async rst ack1", m1_ack, 0);
    chk("async rst timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b0; s_ack = 1'b0; m0_stb = 1'b1; m1_stb = 1'b1;
    @(posedge clk) #1;
    chk("post rst tie cyc", s_cyc, 1);
    chk("post rst tie adr", s_adr, A0);
    s_ack = 1'b1;
    #1 chk("post rst tie ack0", m0_ack, 1);
    m0_stb = 1'b0; m1_stb = 1'b0;
    @(posedge clk) #1 s_ack = 1'b0;
    @(posedge clk) #1 m0_stb = 1'b1;
`ifdef ARB_TIMEOUT_EN
    begin
      int early = 0;
      for (int n = 1; n <= 16; n++) begin
        @(posedge clk) #1;
        if (n < 16) early += m0_ack;
        else begin
          chk("timeout cyc", s_cyc, 1);
          chk("timeout ack0", m0_ack, 1);
          chk("timeout rdt", m0_rdt, 32'hFFFFFFFF);
          chk("timeout ack1", m1_ack, 0);
        end
      end
      chk("timeout early acks", early, 0);
    end
    m0_stb = 1'b0;
    @(posedge clk) #1 s_ack = 1'b1;
    #1;
    chk("after timeout cyc", s_cyc, 0);
    chk("stale ack discarded", m0_ack, 0);
    chk("timeout sticky", timeout, 1);
    repeat (3) @(posedge clk);
    #1 chk("timeout still sticky", timeout, 1);
    s_ack = 1'b0; rst = 1'b1;
    #1 chk("timeout cleared by rst", timeout, 0);
    @(negedge clk) rst = 1'b0;
`else
    begin
      int drops = 0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk) #1;
        drops += !s_cyc + m0_ack + timeout;
      end
      chk("grant held no timeout", drops, 0);
    end
    m0_stb = 1'b0;
    @(posedge clk) #1;
`endif
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
